// File: rtl/game_pad_responder.sv
// Device-side SNES-style serial game pad: answers game_latch/game_clk with button data.
// Define GAME_PAD_ID_EN to append the 4-bit PAD_ID nibble after the button bits.
module game_pad_responder #(
    parameter int unsigned NUM_BITS    = 12,
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        FILL_BIT    = 1'b0,
    parameter logic [3:0]  PAD_ID      = 4'b0000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_BITS-1:0] buttons_i,
    input  logic                game_latch_i,
    input  logic                game_clk_i,
    output logic                game_data_o,
    output logic                busy_o,
    output logic                frame_done_o,
    output logic [4:0]          bit_idx_o
);

`ifdef GAME_PAD_ID_EN
    localparam int unsigned FRAME_LEN = NUM_BITS + 4;
`else
    localparam int unsigned FRAME_LEN = NUM_BITS;
`endif
    localparam logic [4:0] LAST_IDX = 5'(FRAME_LEN - 1);
    localparam logic [4:0] END_IDX  = 5'(FRAME_LEN);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] LOAD  = 2'd1;
    localparam logic [1:0] SHIFT = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [SYNC_STAGES-1:0] latch_sync_q;
    logic [SYNC_STAGES-1:0] clk_sync_q;
    logic                   latch_d1_q;
    logic                   clk_d1_q;
    logic                   latch_s;
    logic                   clk_s;
    logic                   latch_rise;
    logic                   latch_fall;
    logic                   clk_rise;

    logic [1:0]           state_q, state_d;
    // Holds the bits still to come; the current bit lives in data_q.
    logic [FRAME_LEN-2:0] shift_q, shift_d;
    logic                 data_q, data_d;
    logic [4:0]           idx_q, idx_d;
    logic                 done_q, done_d;
    logic [FRAME_LEN-1:0] load_val;

`ifdef GAME_PAD_ID_EN
    assign load_val = {PAD_ID, buttons_i};
`else
    assign load_val = buttons_i;
`endif

    assign latch_s    = latch_sync_q[SYNC_STAGES-1];
    assign clk_s      = clk_sync_q[SYNC_STAGES-1];
    assign latch_rise = latch_s & ~latch_d1_q;
    assign latch_fall = ~latch_s & latch_d1_q;
    assign clk_rise   = clk_s & ~clk_d1_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            latch_sync_q <= '0;
            clk_sync_q   <= '0;
            latch_d1_q   <= 1'b0;
            clk_d1_q     <= 1'b0;
        end else begin
            latch_sync_q <= {latch_sync_q[SYNC_STAGES-2:0], game_latch_i};
            clk_sync_q   <= {clk_sync_q[SYNC_STAGES-2:0], game_clk_i};
            latch_d1_q   <= latch_s;
            clk_d1_q     <= clk_s;
        end
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        data_d  = data_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                data_d = 1'b1;
                if (latch_rise) begin
                    state_d = LOAD;
                    shift_d = load_val[FRAME_LEN-1:1];
                    data_d  = ~load_val[0];
                    idx_d   = 5'd0;
                end
            end
            LOAD: begin
                // Resample every cycle so the last sample before the falling edge wins.
                shift_d = load_val[FRAME_LEN-1:1];
                data_d  = ~load_val[0];
                idx_d   = 5'd0;
                if (latch_fall) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (latch_rise) begin
                    state_d = LOAD;
                    shift_d = load_val[FRAME_LEN-1:1];
                    data_d  = ~load_val[0];
                    idx_d   = 5'd0;
                end else if (clk_rise) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                        data_d  = FILL_BIT;
                        idx_d   = END_IDX;
                        done_d  = 1'b1;
                    end else begin
                        shift_d = shift_q >> 1;
                        data_d  = ~shift_q[0];
                        idx_d   = idx_q + 5'd1;
                    end
                end
            end
            DONE: begin
                data_d = FILL_BIT;
                if (latch_rise) begin
                    state_d = LOAD;
                    shift_d = load_val[FRAME_LEN-1:1];
                    data_d  = ~load_val[0];
                    idx_d   = 5'd0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            data_q  <= 1'b1;
            idx_q   <= 5'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
        end
    end

    assign game_data_o  = data_q;
    assign busy_o       = (state_q == LOAD) || (state_q == SHIFT);
    assign frame_done_o = done_q;
    assign bit_idx_o    = idx_q;

endmodule

// File: tb/tb_game_pad_responder.sv
// Self-checking bench for game_pad_responder: directed and random frames against a
// queue-based model of the serial frame.
module tb_game_pad_responder;

    localparam int         NUM_BITS    = 12;
    localparam int         SYNC_STAGES = 2;
    localparam logic       FILL_BIT    = 1'b0;
    localparam logic [3:0] PAD_ID      = 4'b0000;
`ifdef GAME_PAD_ID_EN
    localparam int FRAME_LEN = NUM_BITS + 4;
`else
    localparam int FRAME_LEN = NUM_BITS;
`endif

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [NUM_BITS-1:0] buttons = '0;
    logic                game_latch = 1'b0;
    logic                game_clk = 1'b0;
    logic                game_data;
    logic                busy;
    logic                frame_done;
    logic [4:0]          bit_idx;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;

    // Expected levels of the bits not yet shifted out, front = bit on the wire now.
    logic exp_q[$];
    bit   m_idle = 1'b1;

    game_pad_responder #(
        .NUM_BITS   (NUM_BITS),
        .SYNC_STAGES(SYNC_STAGES),
        .FILL_BIT   (FILL_BIT),
        .PAD_ID     (PAD_ID)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .buttons_i   (buttons),
        .game_latch_i(game_latch),
        .game_clk_i  (game_clk),
        .game_data_o (game_data),
        .busy_o      (busy),
        .frame_done_o(frame_done),
        .bit_idx_o   (bit_idx)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (frame_done === 1'b1) done_cnt++;

    function automatic void m_latch(input logic [NUM_BITS-1:0] b);
        exp_q.delete();
        for (int i = 0; i < NUM_BITS; i++) exp_q.push_back(~b[i]);
`ifdef GAME_PAD_ID_EN
        for (int i = 0; i < 4; i++) exp_q.push_back(~PAD_ID[i]);
`endif
        m_idle = 1'b0;
    endfunction

    // Returns 1 when this rise consumes the last frame bit.
    function automatic bit m_rise();
        if (m_idle || exp_q.size() == 0) return 1'b0;
        void'(exp_q.pop_front());
        return exp_q.size() == 0;
    endfunction

    function automatic logic exp_data();
        if (m_idle) return 1'b1;
        return (exp_q.size() > 0) ? exp_q[0] : FILL_BIT;
    endfunction

    function automatic int exp_idx();
        return m_idle ? 0 : FRAME_LEN - exp_q.size();
    endfunction

    function automatic logic exp_busy();
        return !m_idle && exp_q.size() > 0;
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".data"}, 32'(game_data), 32'(exp_data()));
        check({tag, ".idx"}, 32'(bit_idx), 32'(exp_idx()));
        check({tag, ".busy"}, 32'(busy), 32'(exp_busy()));
    endtask

    task automatic latch_pulse();
        game_latch = 1'b1;
        cyc($urandom_range(4, 8));
        m_latch(buttons);
        check_all("latch_hi");
        game_latch = 1'b0;
        cyc($urandom_range(4, 8));
        check_all("latch_lo");
    endtask

    task automatic clk_pulse();
        int d0;
        bit ed;
        d0 = done_cnt;
        game_clk = 1'b1;
        cyc($urandom_range(4, 8));
        ed = m_rise();
        check_all("clk_rise");
        game_clk = 1'b0;
        cyc($urandom_range(4, 8));
        check("frame_done", 32'(done_cnt - d0), 32'(ed));
    endtask

    initial begin
        logic [11:0] seq;
        logic [11:0] seq_exp;
        int d0;
        int n;

        // Reset held with random inputs
        for (int i = 0; i < 5; i++) begin
            buttons = NUM_BITS'($urandom);
            game_latch = 1'($urandom);
            game_clk = 1'($urandom);
            cyc(1);
            check("rst.data", 32'(game_data), 32'd1);
            check("rst.busy", 32'(busy), 32'd0);
            check("rst.done", 32'(frame_done), 32'd0);
            check("rst.idx", 32'(bit_idx), 32'd0);
        end
        game_latch = 1'b0;
        game_clk = 1'b0;
        cyc(3);
        rst = 1'b0;
        m_idle = 1'b1;
        cyc(4);
        clk_pulse();
        clk_pulse();
        check_all("idle_after_rst");

        // Full frame with 12'hA5C; buttons scrambled after latching
        buttons = 12'hA5C;
        seq_exp = 12'b010110100011;
        d0 = done_cnt;
        latch_pulse();
        seq[0] = game_data;
        for (int i = 0; i < FRAME_LEN; i++) begin
            buttons = NUM_BITS'($urandom);
            clk_pulse();
            if (i < 11) seq[i+1] = game_data;
        end
        check("frame.seq", 32'(seq), 32'(seq_exp));
        check("frame.done_total", 32'(done_cnt - d0), 32'd1);
        check("frame.idx_end", 32'(bit_idx), 32'(FRAME_LEN));
        check("frame.fill", 32'(game_data), 32'(FILL_BIT));

        // Overclock past the end of the frame
        d0 = done_cnt;
        for (int i = 0; i < 3; i++) clk_pulse();
        check("overclk.done", 32'(done_cnt - d0), 32'd0);

        // Abort after 5 bits with a new latch
        buttons = 12'hA5C;
        d0 = done_cnt;
        latch_pulse();
        for (int i = 0; i < 5; i++) clk_pulse();
        buttons = 12'h001;
        game_latch = 1'b1;
        cyc(SYNC_STAGES);
        check("abort.before", 32'(game_data), 32'(exp_data()));
        cyc(1);
        m_latch(buttons);
        check("abort.data", 32'(game_data), 32'd0);
        check("abort.idx", 32'(bit_idx), 32'd0);
        game_latch = 1'b0;
        cyc(6);
        check_all("abort.settled");
        check("abort.no_done", 32'(done_cnt - d0), 32'd0);
        for (int i = 0; i < FRAME_LEN; i++) clk_pulse();
        check("abort.done_second", 32'(done_cnt - d0), 32'd1);

        // Latch and game clock rising together during SHIFT
        buttons = NUM_BITS'($urandom);
        latch_pulse();
        for (int i = 0; i < 3; i++) clk_pulse();
        buttons = NUM_BITS'($urandom);
        game_latch = 1'b1;
        game_clk = 1'b1;
        cyc(6);
        m_latch(buttons);
        check_all("tie.hi");
        check("tie.idx", 32'(bit_idx), 32'd0);
        game_latch = 1'b0;
        game_clk = 1'b0;
        cyc(6);
        check_all("tie.lo");
        for (int i = 0; i < 2; i++) clk_pulse();

        // Random frames, including early re-latches
        for (int f = 0; f < 8; f++) begin
            buttons = NUM_BITS'($urandom);
            latch_pulse();
            n = $urandom_range(0, FRAME_LEN + 2);
            for (int i = 0; i < n; i++) begin
                buttons = NUM_BITS'($urandom);
                clk_pulse();
            end
        end

        // Reset in the middle of a frame
        buttons = NUM_BITS'($urandom);
        latch_pulse();
        for (int i = 0; i < 4; i++) clk_pulse();
        rst = 1'b1;
        #1;
        exp_q.delete();
        m_idle = 1'b1;
        check("midrst.data", 32'(game_data), 32'd1);
        check("midrst.busy", 32'(busy), 32'd0);
        check("midrst.idx", 32'(bit_idx), 32'd0);
        check("midrst.done", 32'(frame_done), 32'd0);
        cyc(2);
        rst = 1'b0;
        cyc(2);
        clk_pulse();
        clk_pulse();
        check_all("midrst.idle");
        buttons = NUM_BITS'($urandom);
        d0 = done_cnt;
        latch_pulse();
        for (int i = 0; i < FRAME_LEN; i++) clk_pulse();
        check("midrst.recover_done", 32'(done_cnt - d0), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
